// File: rtl/fp32_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp32_mul_seq
// Purpose  : Sequential IEEE-754 single-precision multiplier, S = A * B.
//            Radix-2 shift-add over the 24-bit hidden-bit mantissas into a
//            48-bit accumulator, then a one-cycle normalize/special-case
//            stage. Truncation rounding, subnormals flushed to zero.
//            Fixed latency for every operand: start sampled at edge 0,
//            done high in the cycle after edge 26.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-high reset
//            start - request, sampled only in IDLE
//            A, B  - FP32 operands, sampled with start
//            S     - FP32 result, held from done until the next accepted start
//            busy  - high from the cycle after acceptance through DONE
//            done  - one-cycle pulse, S valid in that cycle
// Revision : 1.0 - initial release
// ============================================================================
module fp32_mul_seq #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_MUL  = 2'd1;
    localparam logic [1:0] c_NORM = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]        r_state;
    logic              r_signS;
    logic [23:0]       r_fracA;
    logic [23:0]       r_fracB;
    logic [47:0]       r_acc;
    logic signed [9:0] r_exp;
    logic [4:0]        r_count;
    logic              r_nanIn;
    logic              r_infIn;
    logic              r_zeroIn;

    // Operand classification at latch time
    logic w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB;
    assign w_zeroA = (A[30:23] == 8'h00);
    assign w_zeroB = (B[30:23] == 8'h00);
    assign w_infA  = (&A[30:23]) & ~(|A[22:0]);
    assign w_infB  = (&B[30:23]) & ~(|B[22:0]);
    assign w_nanA  = (&A[30:23]) & (|A[22:0]);
    assign w_nanB  = (&B[30:23]) & (|B[22:0]);

    // 10-bit signed exponent sum leaves headroom for both overflow (up to 383)
    // and underflow (down to -127) without wrapping.
    logic signed [9:0] w_expSum;
    assign w_expSum = signed'({2'b00, A[30:23]}) + signed'({2'b00, B[30:23]}) - 10'sd127;

    // Partial product for the current multiplier bit
    logic [47:0] w_addend;
    assign w_addend = {24'h000000, r_fracA} << r_count;

    // Product of two [1,2) mantissas lies in [1,4): bit 47 flags the upper half
    logic [22:0]       w_mant;
    logic signed [9:0] w_expNorm;
    assign w_mant    = r_acc[47] ? r_acc[46:24] : r_acc[45:23];
    assign w_expNorm = r_acc[47] ? (r_exp + 10'sd1) : r_exp;

    logic [31:0] w_result;
    always_comb begin
        w_result = {r_signS, w_expNorm[7:0], w_mant};
        if (r_nanIn || (r_infIn && r_zeroIn)) begin
            w_result = QNAN;
        end else if (r_infIn) begin
            w_result = {r_signS, 8'hFF, 23'h000000};
        end else if (r_zeroIn) begin
            w_result = {r_signS, 31'h00000000};
        end else if (w_expNorm >= 10'sd255) begin
            w_result = {r_signS, 8'hFF, 23'h000000};
        end else if (w_expNorm <= 10'sd0) begin
            w_result = {r_signS, 31'h00000000};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_signS  <= 1'b0;
            r_fracA  <= '0;
            r_fracB  <= '0;
            r_acc    <= '0;
            r_exp    <= '0;
            r_count  <= '0;
            r_nanIn  <= 1'b0;
            r_infIn  <= 1'b0;
            r_zeroIn <= 1'b0;
            S        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_signS  <= A[31] ^ B[31];
                        r_fracA  <= {1'b1, A[22:0]};
                        r_fracB  <= {1'b1, B[22:0]};
                        r_exp    <= w_expSum;
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_nanIn  <= w_nanA | w_nanB;
                        r_infIn  <= w_infA | w_infB;
                        r_zeroIn <= w_zeroA | w_zeroB;
                        busy     <= 1'b1;
                        r_state  <= c_MUL;
                    end
                end
                c_MUL: begin
                    // Bits 0..23 are accumulated; count reaching 24 ends the loop
                    if (r_count == 5'd24) begin
                        r_state <= c_NORM;
                    end else begin
                        if (r_fracB[r_count]) begin
                            r_acc <= r_acc + w_addend;
                        end
                        r_count <= r_count + 5'd1;
                    end
                end
                c_NORM: begin
                    S       <= w_result;
                    done    <= 1'b1;
                    r_state <= c_DONE;
                end
                c_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp32_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp32_mul_seq
// Purpose  : Directed self-checking bench for fp32_mul_seq: reset state,
//            arithmetic vectors, special operands, overflow/underflow,
//            start/done handshake and asynchronous reset mid-operation.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp32_mul_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    fp32_mul_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .S     (s),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one operation from a negedge and wait for done. Returns the result,
    // the number of negedges from the first one after the accepting edge until
    // done (-1 on timeout), how often busy was low before done, and the
    // busy/done values in the done cycle and the cycle after. Ends at the
    // negedge of the cycle after done.
    task automatic runOp(input logic [31:0] opA, input logic [31:0] opB,
                         output logic [31:0] res, output int lat, output int busyLow,
                         output logic busyAtDone, output logic doneNext,
                         output logic busyNext);
        a = opA;
        b = opB;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        busyLow = 0;
        busyAtDone = 1'b0;
        doneNext = 1'b1;
        busyNext = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) busyLow++;
            @(negedge clk);
        end
        res = s;
        busyAtDone = busy;
        if (lat >= 0) begin
            @(negedge clk);
            doneNext = done;
            busyNext = busy;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (s !== 32'h0) begin failures++; $display("FAIL reset_S got=%h exp=%h", s, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        runOp(32'h40000000, 32'h40400000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h40C00000) begin failures++; $display("FAIL basic_2x3 got=%h exp=%h", res, 32'h40C00000); end
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL basic_latency got=%0d exp=26", lat); end
        checks++;
        if (busyLow !== 0) begin failures++; $display("FAIL basic_busy_low_cycles got=%0d exp=0", busyLow); end
        checks++;
        if (bd !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=1", bd); end
        checks++;
        if (dn !== 1'b0) begin failures++; $display("FAIL basic_done_pulse_width got=%b exp=0", dn); end
        checks++;
        if (bn !== 1'b0) begin failures++; $display("FAIL basic_busy_after_done got=%b exp=0", bn); end
        checks++;
        if (s !== 32'h40C00000) begin failures++; $display("FAIL basic_S_held got=%h exp=%h", s, 32'h40C00000); end
    endtask

    task automatic test_normalize;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        runOp(32'h3FC00000, 32'h3FC00000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h40100000) begin failures++; $display("FAIL norm_1p5x1p5 got=%h exp=%h", res, 32'h40100000); end
        runOp(32'hC0000000, 32'h3F000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'hBF800000) begin failures++; $display("FAIL norm_neg2xhalf got=%h exp=%h", res, 32'hBF800000); end
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL norm_latency got=%0d exp=26", lat); end
    endtask

    task automatic test_specials;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        runOp(32'h7F800000, 32'h00000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h7FC00000) begin failures++; $display("FAIL spec_inf_x_zero got=%h exp=%h", res, 32'h7FC00000); end
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL spec_latency got=%0d exp=26", lat); end
        runOp(32'hFF800000, 32'h40000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'hFF800000) begin failures++; $display("FAIL spec_neginf_x_2 got=%h exp=%h", res, 32'hFF800000); end
        runOp(32'h7FC00001, 32'h40400000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h7FC00000) begin failures++; $display("FAIL spec_nan_x_3 got=%h exp=%h", res, 32'h7FC00000); end
        runOp(32'h40400000, 32'h80000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h80000000) begin failures++; $display("FAIL spec_3_x_negzero got=%h exp=%h", res, 32'h80000000); end
    endtask

    task automatic test_range;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        runOp(32'h7F000000, 32'h7F000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h7F800000) begin failures++; $display("FAIL range_overflow got=%h exp=%h", res, 32'h7F800000); end
        runOp(32'h00800000, 32'h00800000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h00000000) begin failures++; $display("FAIL range_underflow got=%h exp=%h", res, 32'h00000000); end
        runOp(32'h80800000, 32'h00800000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h80000000) begin failures++; $display("FAIL range_neg_underflow got=%h exp=%h", res, 32'h80000000); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        // First op 2*3, with a second start pulsed while busy
        a = 32'h40000000;
        b = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (k == 5) begin
                a = 32'h3FC00000;
                b = 32'h3FC00000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL b2b_ignored_latency got=%0d exp=26", lat); end
        checks++;
        if (s !== 32'h40C00000) begin failures++; $display("FAIL b2b_ignored_result got=%h exp=%h", s, 32'h40C00000); end
        @(negedge clk);
        // Start in the cycle right after done
        runOp(32'hC0000000, 32'h3F000000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'hBF800000) begin failures++; $display("FAIL b2b_second_result got=%h exp=%h", res, 32'hBF800000); end
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL b2b_second_latency got=%0d exp=26", lat); end
    endtask

    task automatic test_reset_midop;
        logic [31:0] res;
        int lat, busyLow;
        logic bd, dn, bn;
        logic sawDone;
        a = 32'h3FC00000;
        b = 32'h3FC00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
        checks++;
        if (s !== 32'hBF800000) begin failures++; $display("FAIL midop_S_held got=%h exp=%h", s, 32'hBF800000); end
        rst = 1'b1;
        #1;
        checks++;
        if (s !== 32'h0) begin failures++; $display("FAIL midop_async_S got=%h exp=%h", s, 32'h0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midop_async_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL midop_async_done got=%b exp=0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0) begin failures++; $display("FAIL midop_no_done got=%b exp=0", sawDone); end
        runOp(32'h40000000, 32'h40400000, res, lat, busyLow, bd, dn, bn);
        checks++;
        if (res !== 32'h40C00000) begin failures++; $display("FAIL midop_fresh_result got=%h exp=%h", res, 32'h40C00000); end
        checks++;
        if (lat !== 26) begin failures++; $display("FAIL midop_fresh_latency got=%0d exp=26", lat); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_basic();
        test_normalize();
        test_specials();
        test_range();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp32_mul_seq.md
Name: fp32_mul_seq

Overview:
- Sequential IEEE-754 single-precision multiplier; the inverse operation of the team's FP32 divider.
- Same format conventions as the divider: hidden-bit mantissas, biased exponents, sign by XOR, truncation rounding, special-case override stage.
- Computes S = A*B with a radix-2 shift-add mantissa datapath over a fixed number of cycles.
- Sits beside the divider in the FPAU, selected by the 3-bit op select; provides a start/done handshake so the FPAU controller can sequence it.

Parameters:
- QNAN, 32'h7FC00000, canonical NaN pattern driven for invalid operations.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  32  operand A, FP32; sampled with start.
- B  input  32  operand B, FP32; sampled with start.
- S  output  32  result; held stable from done until the next accepted start.
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse; S is valid in that cycle.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, S=0, busy=0, done=0, internal registers cleared. A reset asserted mid-operation aborts it; no done pulse is produced for the aborted operation.
- States: IDLE, MUL, NORM, DONE.
- IDLE, start=1: latch A and B; signS=A[31]^B[31]; fracA={1,A[22:0]}; fracB={1,B[22:0]}. Compute exp as signed 10-bit: A[30:23]+B[30:23]-127. Clear the 48-bit product accumulator and set count=0. Go to MUL.
- MUL: each cycle, if multiplier bit fracB[count]=1, add fracA<<count into the accumulator. Increment count. After 24 cycles (count=23 processed), go to NORM.
- NORM:
  - If P[47]=1: mantissa=P[46:24], exp=exp+1.
  - Otherwise: mantissa=P[45:23].
  - Rounding is truncation only.
- DONE: S registered, done=1 for exactly this cycle, then go to IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge 26. Fixed for all operands, including special cases.
- Throughput: a new start is accepted no earlier than the cycle after DONE, i.e. back-to-back issue is allowed once busy is low.
- start while busy is ignored and has no effect on the current operation.
- Operand classes (decoded at latch time, applied in NORM):
  - exp field 0 → zero. Subnormals are flushed to zero.
  - exp field 255 with frac=0 → Inf.
  - exp field 255 with frac≠0 → NaN.
- Result priority, highest first:
  - Either operand NaN → QNAN.
  - Inf × zero → QNAN.
  - Either operand Inf → {signS, 8'hFF, 23'h0}.
  - Either operand zero → {signS, 31'h0}.
  - Final exp ≥ 255 → {signS, 8'hFF, 23'h0} (overflow).
  - Final exp ≤ 0 → {signS, 31'h0} (underflow flush).
  - Otherwise → {signS, exp[7:0], mantissa}.
- Exponent arithmetic uses 10-bit signed math so that overflow and underflow are detected without wrap-around.
- The accumulator is 48 bits; no carry is lost because 24×24 ≤ 48 bits.

Test Plan:
- A=0x40000000, B=0x40400000 (2.0×3.0), start one cycle → done exactly 26 cycles later, S=0x40C00000; busy high throughout.
- A=0x3FC00000, B=0x3FC00000 (1.5×1.5) → normalize path with P[47]=1, S=0x40100000. Also A=0xC0000000, B=0x3F000000 → S=0xBF800000.
- Specials:
  - A=0x7F800000, B=0x00000000 → S=0x7FC00000.
  - A=0xFF800000, B=0x40000000 → S=0xFF800000.
  - A=0x7FC00001 with any B → S=0x7FC00000.
- Overflow/underflow: A=B=0x7F000000 → S=0x7F800000. A=B=0x00800000 → S=0x00000000. A=0x80800000, B=0x00800000 → S=0x80000000.
- Handshake: pulse start again at cycle 5 with different operands → ignored, first result unchanged. Start in the cycle after done → accepted, second result correct.
- Reset mid-operation: assert rst at cycle 10 of MUL → outputs zero immediately (asynchronous), no done pulse. A fresh start after rst deasserts completes normally.
